// File: rtl/rtc_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_scheduler
//  Purpose  : Arbitrates RTC register-bus traffic between a periodic 11-register
//             read sweep and user single-register writes, one transaction at a time.
//  Revision : 1.0  initial release
// ============================================================================
module rtc_bus_scheduler #(
   parameter logic [15:0] READ_PERIOD = 16'd50000,
   parameter logic [11:0] TIMEOUT     = 12'd1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       bus_start,
   output logic       bus_rw,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   input  logic       bus_done,
   input  logic [7:0] bus_rdata,
   output logic       rd_valid,
   output logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       sweep_done,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [3:0] c_last_idx = 4'd10;

   state_t      state_q,   state_d;
   logic [15:0] period_q,  period_d;
   logic        pending_q, pending_d;
   logic [3:0]  idx_q,     idx_d;
   logic [11:0] wait_q,    wait_d;
   logic        rw_q,      rw_d;
   logic [7:0]  addr_q,    addr_d;
   logic [7:0]  wdata_q,   wdata_d;
   logic [7:0]  rdata_q,   rdata_d;
   logic        abort_q,   abort_d;
   logic        sdone_q,   sdone_d;

   logic [7:0]  w_sweep_addr;
   logic        w_period_wrap;
   logic        w_finish;

   always_comb begin
      case (idx_q)
         4'd0:    w_sweep_addr = 8'h21;
         4'd1:    w_sweep_addr = 8'h22;
         4'd2:    w_sweep_addr = 8'h23;
         4'd3:    w_sweep_addr = 8'h24;
         4'd4:    w_sweep_addr = 8'h25;
         4'd5:    w_sweep_addr = 8'h26;
         4'd6:    w_sweep_addr = 8'h27;
         4'd7:    w_sweep_addr = 8'h28;
         4'd8:    w_sweep_addr = 8'h41;
         4'd9:    w_sweep_addr = 8'h42;
         default: w_sweep_addr = 8'h43;
      endcase
   end

   assign w_period_wrap = (period_q == READ_PERIOD - 16'd1);
   assign period_d      = w_period_wrap ? 16'd0 : period_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      abort_d   = abort_q;
      sdone_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               addr_d  = wr_addr;
               wdata_d = wr_data;
               rw_d    = 1'b0;
               state_d = ISSUE;
            end else if (pending_q) begin
               addr_d  = w_sweep_addr;
               rw_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wait_d  = 12'd0;
            abort_d = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus_done) begin
               rdata_d = bus_rdata;
               state_d = FINISH;
            end else if (wait_q == TIMEOUT - 12'd1) begin
               abort_d = 1'b1;
               state_d = FINISH;
            end else begin
               wait_d = wait_q + 12'd1;
            end
         end
         FINISH: begin
            state_d = IDLE;
            // Aborted reads still consume their slot so a dead register cannot stall the sweep
            if (rw_q) begin
               if (idx_q == c_last_idx) begin
                  idx_d     = 4'd0;
                  pending_d = 1'b0;
                  sdone_d   = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (w_period_wrap) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         period_q  <= 16'd0;
         pending_q <= 1'b0;
         idx_q     <= 4'd0;
         wait_q    <= 12'd0;
         rw_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         rdata_q   <= 8'h00;
         abort_q   <= 1'b0;
         sdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         wait_q    <= wait_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         abort_q   <= abort_d;
         sdone_q   <= sdone_d;
      end
   end

   assign w_finish    = (state_q == FINISH);
   assign bus_start   = (state_q == ISSUE);
   assign busy        = (state_q != IDLE);
   assign bus_rw      = rw_q;
   assign bus_addr    = addr_q;
   assign bus_wdata   = wdata_q;
   assign wr_ack      = w_finish & ~rw_q;
   assign rd_valid    = w_finish & rw_q & ~abort_q;
   assign timeout_err = w_finish & abort_q;
   assign rd_addr     = addr_q;
   assign rd_data     = rdata_q;
   // Registered, so it follows the FINISH of register 0x43 by one cycle
   assign sweep_done  = sdone_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_bus_scheduler
//  Purpose  : Scoreboard bench for rtc_bus_scheduler with a bus-controller model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtc_bus_scheduler;

   localparam logic [15:0] READ_PERIOD = 16'd64;
   localparam logic [11:0] TIMEOUT     = 12'd16;
   localparam int          TO_CYC      = 16;
   // Counter wraps at 63, pending seen in IDLE at 64, launch one cycle later
   localparam int          FIRST_START = 65;

   logic       clk = 1'b0, reset = 1'b1, wr_req = 1'b0, bus_done = 1'b0;
   logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, bus_rdata = 8'h00;
   logic       wr_ack, bus_start, bus_rw, rd_valid, sweep_done, busy, timeout_err;
   logic [7:0] bus_addr, bus_wdata, rd_addr, rd_data;

   rtc_bus_scheduler #(.READ_PERIOD(READ_PERIOD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .bus_start(bus_start), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_done(bus_done), .bus_rdata(bus_rdata),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .sweep_done(sweep_done), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      int         cyc;
      bit         rd;
      bit         ack;
      bit         to;
      bit         is_rd;
      logic [7:0] addr;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] wr_q[$];
   int          done_at[$];
   logic [7:0]  sweep_tab [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                   8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0;
   int   sweep_k = 0, sd_cyc = -1, first_start = -1, last_start = -1, wr_start = -1;
   int   n_rd = 0, n_to = 0, n_sd = 0, n_start = 0;
   logic [7:0] last_addr = 8'h00;
   bit   last_rw = 1'b0;
   bit   wr_seen = 1'b0;
   int   rsp_mode = 0;
   bit   noans23 = 1'b0, glitch_next = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
      wr_seen <= wr_req;
   end

   task automatic chk_eq(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Controller model: decides when bus_done fires and records the outcome the
   // scheduler must report, from the WAIT-window and timeout rules.
   task automatic plan_response();
      int   ks[$];
      int   acc;
      exp_t e;
      if (glitch_next && bus_rw) begin
         ks.push_back(0);
         ks.push_back(3);
         glitch_next = 1'b0;
      end else if (noans23 && bus_rw && bus_addr == 8'h23) begin
         ks.delete();
      end else if (rsp_mode == 0) begin
         ks.push_back(4);
      end else begin
         ks.push_back(int'($urandom_range(1, 18)));
         if ($urandom_range(0, 7) == 0) ks.push_back(0);
      end
      acc = -1;
      foreach (ks[i])
         if (ks[i] >= 1 && ks[i] <= TO_CYC && (acc < 0 || ks[i] < acc)) acc = ks[i];
      e.is_rd = bus_rw;
      e.addr  = bus_addr;
      e.to    = (acc < 0);
      e.rd    = bus_rw && (acc >= 0);
      e.ack   = !bus_rw;
      e.cyc   = cyc + ((acc < 0) ? TO_CYC + 1 : acc + 1);
      exp_q.push_back(e);
      foreach (ks[i]) done_at.push_back(cyc + ks[i]);
   endtask

   task automatic drive_done();
      bit hit = 1'b0;
      foreach (done_at[i]) if (done_at[i] == cyc) hit = 1'b1;
      bus_done  = hit;
      bus_rdata = hit ? (bus_addr ^ 8'hFF) : 8'($urandom);
      for (int i = done_at.size() - 1; i >= 0; i--)
         if (done_at[i] < cyc) done_at.delete(i);
   endtask

   initial forever begin
      @(negedge clk);
      if (bus_start) plan_response();
      drive_done();
   end

   task automatic monitor_cycle();
      exp_t e;
      if (bus_start) begin
         n_start++;
         if (first_start < 0) first_start = cyc;
         if (last_start >= 0) chk_eq("start_spacing_ge3", int'(cyc - last_start >= 3), 1);
         last_start = cyc;
         last_addr  = bus_addr;
         last_rw    = bus_rw;
         chk_eq("start_write_priority", int'(bus_rw), int'(!wr_seen));
         if (bus_rw) begin
            chk_eq("sweep_addr_order", int'(bus_addr), int'(sweep_tab[sweep_k]));
            sweep_k = (sweep_k + 1) % 11;
         end else if (wr_q.size() == 0) begin
            chk_eq("write_without_request", wr_q.size(), 1);
         end else begin
            chk_eq("write_addr_data", int'({bus_addr, bus_wdata}), int'(wr_q.pop_front()));
            wr_start = cyc;
         end
      end
      if (rd_valid | wr_ack | timeout_err) begin
         if (rd_valid) n_rd++;
         if (timeout_err) n_to++;
         if (exp_q.size() == 0) begin
            chk_eq("unexpected_pulse", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk_eq("finish_cycle", cyc, e.cyc);
            chk_eq("finish_flags", int'({rd_valid, wr_ack, timeout_err}), int'({e.rd, e.ack, e.to}));
            if (e.rd) chk_eq("rd_addr_data", int'({rd_addr, rd_data}), int'({e.addr, e.addr ^ 8'hFF}));
            if (e.is_rd && e.addr == 8'h43) sd_cyc = cyc + 1;
         end
      end
      if (sweep_done) n_sd++;
      if (sweep_done || cyc == sd_cyc) chk_eq("sweep_done", int'(sweep_done), int'(cyc == sd_cyc));
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         chk_eq("missing_finish", cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
   endtask

   initial forever begin
      @(negedge clk);
      monitor_cycle();
   end

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      wr_req = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete(); wr_q.delete(); done_at.delete();
      sweep_k = 0; sd_cyc = -1; first_start = -1; last_start = -1; wr_start = -1;
      n_rd = 0; n_to = 0; n_sd = 0; n_start = 0; last_rw = 1'b0;
      glitch_next = 1'b0; noans23 = 1'b0;
      @(negedge clk);
      chk_eq("reset_ctrl_zero", int'({wr_ack, bus_start, bus_rw, rd_valid, sweep_done, busy, timeout_err}), 0);
      chk_eq("reset_data_zero", int'({bus_addr, bus_wdata, rd_addr, rd_data}), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      int i;
      wr_q.push_back({a, d});
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      for (i = 0; i < 300 && !wr_ack; i++) @(negedge clk);
      chk_eq("wr_ack_seen", int'(wr_ack), 1);
      wr_req = 1'b0;
   endtask

   initial begin
      int ns, s25;

      // Plain sweep after reset
      do_reset();
      for (int i = 0; i < 400 && n_rd < 11; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk_eq("t1_read_count", n_rd, 11);
      chk_eq("t1_first_start_cycle", first_start, FIRST_START);
      chk_eq("t1_sweep_done_count", n_sd, 1);

      // Write coinciding with sweep_pending wins
      do_reset();
      while (cyc < 64) @(negedge clk);
      do_write(8'h22, 8'h15);
      chk_eq("t2_write_start_cycle", wr_start, FIRST_START);
      for (int i = 0; i < 50 && n_start < 2; i++) @(negedge clk);
      chk_eq("t2_then_read_21", int'({last_rw, last_addr}), int'({1'b1, 8'h21}));

      // Write arriving while 0x25 is in flight
      do_reset();
      for (int i = 0; i < 300 && !(last_start >= 0 && last_rw && last_addr == 8'h25); i++) @(negedge clk);
      s25 = last_start;
      @(negedge clk);
      do_write(8'h30, 8'hA5);
      chk_eq("t3_write_after_25", wr_start, s25 + 7);
      ns = n_start;
      for (int i = 0; i < 50 && n_start == ns; i++) @(negedge clk);
      chk_eq("t3_resume_at_26", int'({last_rw, last_addr}), int'({1'b1, 8'h26}));

      // Unanswered read of 0x23
      do_reset();
      noans23 = 1'b1;
      for (int i = 0; i < 400 && n_to < 1; i++) @(negedge clk);
      chk_eq("t4_timeout_count", n_to, 1);
      chk_eq("t4_reads_before_timeout", n_rd, 2);
      ns = n_start;
      for (int i = 0; i < 50 && n_start == ns; i++) @(negedge clk);
      chk_eq("t4_next_addr_24", int'({last_rw, last_addr}), int'({1'b1, 8'h24}));
      noans23 = 1'b0;

      // Reset while waiting on 0x27
      do_reset();
      for (int i = 0; i < 300 && !(last_start >= 0 && last_rw && last_addr == 8'h27); i++) @(negedge clk);
      do_reset();
      for (int i = 0; i < 200 && first_start < 0; i++) @(negedge clk);
      chk_eq("t5_restart_cycle", first_start, FIRST_START);
      chk_eq("t5_restart_addr", int'(last_addr), 8'h21);

      // bus_done in ISSUE is ignored
      do_reset();
      glitch_next = 1'b1;
      while (cyc < FIRST_START + 9) @(negedge clk);
      chk_eq("t6_single_rd_valid", n_rd, 1);

      // Randomized writes and controller latencies
      do_reset();
      rsp_mode = 1;
      for (int w = 0; w < 40; w++) begin
         repeat ($urandom_range(1, 120)) @(negedge clk);
         do_write(8'($urandom), 8'($urandom));
      end
      rsp_mode = 0;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk_eq("final_scoreboard_empty", exp_q.size(), 0);
      chk_eq("final_writes_consumed", wr_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no end of test, expected summary");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
